// File: rtl/adxl_spi_responder.sv
// ADXL362-style SPI mode-0 responder: serves a byte register file to an SPI master, with a host write port.
// Optional feature macro: ADXL_SPI_RESP_AUTOINC_EN (burst address auto-increment with wrap).
module adxl_spi_responder #(
  parameter int unsigned ADDR_W = 6,
  parameter logic [7:0]  CMD_WR = 8'h0A,
  parameter logic [7:0]  CMD_RD = 8'h0B
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_wdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              cmd_err,
  output logic              busy
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_WDATA  = 3'd3;
  localparam logic [2:0] S_RDATA  = 3'd4;
  localparam logic [2:0] S_IGNORE = 3'd5;

  localparam logic [ADDR_W-1:0] A_DEVID_AD = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_DEVID_MST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_PARTID = ADDR_W'(2);

  logic [2:0]        state, state_nx;
  logic              sclk_s1, sclk_s2, sclk_d;
  logic              cs_s1, cs_s2, cs_d;
  logic              mosi_s1, mosi_s2;
  logic [2:0]        bit_cnt;
  logic [6:0]        rx_sh;
  logic [7:0]        tx_sh;
  logic [ADDR_W-1:0] addr, addr_nx;
  logic              rd_mode;
  logic [7:0]        regs [DEPTH];

  logic              sclk_rise_c, sclk_fall_c, cs_fall_c, cs_rise_c;
  logic              byte_done_c, cmd_ok_c, load_c, commit_c;
  logic [7:0]        byte_c;

  // Pin synchronisers; cs_n resets to its idle level so reset release cannot fake a select.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_d    <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      cs_s1   <= cs_n;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  // sclk events only count while selected, which also gives cs_n rise priority.
  assign sclk_rise_c = sclk_s2 & ~sclk_d & ~cs_s2;
  assign sclk_fall_c = ~sclk_s2 & sclk_d & ~cs_s2;
  assign cs_fall_c   = ~cs_s2 & cs_d;
  assign cs_rise_c   = cs_s2 & ~cs_d;

  assign byte_c      = {rx_sh, mosi_s2};
  assign byte_done_c = sclk_rise_c & ~cs_fall_c & (bit_cnt == 3'd7);
  assign cmd_ok_c    = (byte_c == CMD_WR) || (byte_c == CMD_RD);
  assign load_c      = byte_done_c & (((state == S_ADDR) & rd_mode) | (state == S_RDATA));
  assign commit_c    = byte_done_c & (state == S_WDATA);

  // Bit counter and receive shifter.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= 3'd0;
      rx_sh   <= 7'd0;
    end else if (cs_fall_c || cs_rise_c) begin
      bit_cnt <= 3'd0;
    end else if (sclk_rise_c) begin
      bit_cnt <= bit_cnt + 3'd1;
      rx_sh   <= byte_c[6:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (cs_fall_c) state_nx = S_CMD;
      S_CMD:   if (byte_done_c) state_nx = cmd_ok_c ? S_ADDR : S_IGNORE;
      S_ADDR:  if (byte_done_c) state_nx = rd_mode ? S_RDATA : S_WDATA;
      S_WDATA, S_RDATA, S_IGNORE: state_nx = state;
      default: state_nx = S_IDLE;
    endcase
    if (cs_rise_c) state_nx = S_IDLE;
  end

  // Address for the next data byte; also the read-ahead address for the tx load.
  always_comb begin
    addr_nx = addr;
    if (byte_done_c && state == S_ADDR) begin
      addr_nx = byte_c[ADDR_W-1:0];
    end else if (byte_done_c && (state == S_WDATA || state == S_RDATA)) begin
`ifdef ADXL_SPI_RESP_AUTOINC_EN
      addr_nx = addr + 1'b1;
`else
      addr_nx = addr;
`endif
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      rd_mode   <= 1'b0;
      tx_sh     <= 8'h00;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      busy      <= 1'b0;
      cmd_err   <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'h00;
    end else begin
      addr    <= addr_nx;
      miso_oe <= ~cs_s2;
      busy    <= (state_nx != S_IDLE);
      cmd_err <= (state == S_CMD) & byte_done_c & ~cmd_ok_c;
      if (state == S_CMD && byte_done_c) rd_mode <= (byte_c == CMD_RD);

      if (load_c) begin
        tx_sh <= regs[addr_nx];
      end else if (sclk_fall_c && state == S_RDATA) begin
        tx_sh <= {tx_sh[6:0], 1'b0};
      end

      if (state_nx != S_RDATA) begin
        miso <= 1'b0;
      end else if (sclk_fall_c && state == S_RDATA) begin
        miso <= tx_sh[7];
      end

      wr_strobe <= commit_c && (addr > A_PARTID);
      if (commit_c && (addr > A_PARTID)) begin
        wr_addr <= addr;
        wr_data <= byte_c;
      end
    end
  end

  // Register file; the later host write overrides a same-cycle SPI commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[ADDR_W'(i)] <= 8'h00;
      regs[A_DEVID_AD]  <= 8'hAD;
      regs[A_DEVID_MST] <= 8'h1D;
      regs[A_PARTID]    <= 8'hF2;
    end else begin
      if (commit_c && (addr > A_PARTID)) regs[addr] <= byte_c;
      if (host_we) regs[host_addr] <= host_wdata;
    end
  end

endmodule

// File: tb/tb_adxl_spi_responder.sv
// Directed bench for adxl_spi_responder: table of SPI transactions plus hand-written host/reset sequences.
module tb_adxl_spi_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk, cs_n, mosi;
  logic       miso, miso_oe;
  logic       host_we;
  logic [5:0] host_addr;
  logic [7:0] host_wdata;
  logic       wr_strobe;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;
  logic       cmd_err, busy;

  adxl_spi_responder dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .wr_data(wr_data), .cmd_err(cmd_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int wr_cnt, err_cnt;
  logic [5:0] last_wa;
  logic [7:0] last_wd;
  logic       mid_busy, mid_oe;

  // Pulse monitor: each cycle high counts once, so a 1-clk pulse counts exactly 1.
  always @(posedge clk) begin
    if (wr_strobe) begin
      wr_cnt  = wr_cnt + 1;
      last_wa = wr_addr;
      last_wd = wr_data;
    end
    if (cmd_err) err_cnt = err_cnt + 1;
  end

  typedef struct {
    int              n;
    int              cut;
    logic [0:4][7:0] tx;
    logic [0:4][7:0] erx;
    logic [0:4]      rchk;
    int              ewr;
    logic [5:0]      ewa;
    logic [7:0]      ewd;
    int              eerr;
  } vec_t;

  localparam int NV = 12;
  vec_t v [NV];
  logic [0:4][7:0] rx;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cs_lo();
    @(negedge clk);
    cs_n = 1'b0;
    #80;
    mid_busy = busy;
    mid_oe   = miso_oe;
  endtask

  task automatic cs_hi();
    #80;
    cs_n = 1'b1;
    mosi = 1'b0;
    #240;
  endtask

  task automatic send_bits(input logic [7:0] b, input int nb, output logic [7:0] r);
    r = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      mosi = b[i];
      #80;
      sclk = 1'b1;
      r[i] = miso;
      #80;
      sclk = 1'b0;
    end
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] r;
    cs_lo();
    send_bits(8'h0B, 8, r);
    send_bits(a, 8, r);
    send_bits(8'h00, 8, r);
    cs_hi();
    chk(nm, {24'h0, r}, {24'h0, exp});
  endtask

  initial begin
    logic [7:0] r;
    rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    host_we = 1'b0; host_addr = 6'h00; host_wdata = 8'h00;
    wr_cnt = 0; err_cnt = 0; last_wa = 6'h00; last_wd = 8'h00;

    v[0]  = '{n:3, cut:0, tx:{8'h0B,8'h00,8'h00,8'h00,8'h00}, erx:{8'h00,8'h00,8'hAD,8'h00,8'h00},
              rchk:5'b11100, ewr:0, ewa:6'h00, ewd:8'h00, eerr:0};
`ifdef ADXL_SPI_RESP_AUTOINC_EN
    v[1]  = '{n:5, cut:0, tx:{8'h0B,8'h00,8'h00,8'h00,8'h00}, erx:{8'h00,8'h00,8'hAD,8'h1D,8'hF2},
              rchk:5'b00111, ewr:0, ewa:6'h00, ewd:8'h00, eerr:0};
`else
    v[1]  = '{n:5, cut:0, tx:{8'h0B,8'h00,8'h00,8'h00,8'h00}, erx:{8'h00,8'h00,8'hAD,8'hAD,8'hAD},
              rchk:5'b00111, ewr:0, ewa:6'h00, ewd:8'h00, eerr:0};
`endif
    v[2]  = '{n:3, cut:0, tx:{8'h0A,8'h2D,8'h02,8'h00,8'h00}, erx:'0,
              rchk:5'b00000, ewr:1, ewa:6'h2D, ewd:8'h02, eerr:0};
    v[3]  = '{n:3, cut:0, tx:{8'h0B,8'h2D,8'h00,8'h00,8'h00}, erx:{8'h00,8'h00,8'h02,8'h00,8'h00},
              rchk:5'b00100, ewr:0, ewa:6'h00, ewd:8'h00, eerr:0};
    v[4]  = '{n:3, cut:0, tx:{8'h0A,8'h00,8'h55,8'h00,8'h00}, erx:'0,
              rchk:5'b00000, ewr:0, ewa:6'h00, ewd:8'h00, eerr:0};
    v[5]  = '{n:3, cut:0, tx:{8'h0B,8'h00,8'h00,8'h00,8'h00}, erx:{8'h00,8'h00,8'hAD,8'h00,8'h00},
              rchk:5'b00100, ewr:0, ewa:6'h00, ewd:8'h00, eerr:0};
    v[6]  = '{n:3, cut:0, tx:{8'h55,8'h12,8'h34,8'h00,8'h00}, erx:'0,
              rchk:5'b11100, ewr:0, ewa:6'h00, ewd:8'h00, eerr:1};
    v[7]  = '{n:3, cut:0, tx:{8'h0B,8'h01,8'h00,8'h00,8'h00}, erx:{8'h00,8'h00,8'h1D,8'h00,8'h00},
              rchk:5'b00100, ewr:0, ewa:6'h00, ewd:8'h00, eerr:0};
    v[8]  = '{n:3, cut:4, tx:{8'h0A,8'h20,8'hFF,8'h00,8'h00}, erx:'0,
              rchk:5'b00000, ewr:0, ewa:6'h00, ewd:8'h00, eerr:0};
    v[9]  = '{n:3, cut:0, tx:{8'h0B,8'h20,8'h00,8'h00,8'h00}, erx:{8'h00,8'h00,8'h00,8'h00,8'h00},
              rchk:5'b00100, ewr:0, ewa:6'h00, ewd:8'h00, eerr:0};
`ifdef ADXL_SPI_RESP_AUTOINC_EN
    v[10] = '{n:4, cut:0, tx:{8'h0A,8'h30,8'h11,8'h22,8'h00}, erx:'0,
              rchk:5'b00000, ewr:2, ewa:6'h31, ewd:8'h22, eerr:0};
    v[11] = '{n:4, cut:0, tx:{8'h0B,8'h30,8'h00,8'h00,8'h00}, erx:{8'h00,8'h00,8'h11,8'h22,8'h00},
              rchk:5'b00110, ewr:0, ewa:6'h00, ewd:8'h00, eerr:0};
`else
    v[10] = '{n:4, cut:0, tx:{8'h0A,8'h30,8'h11,8'h22,8'h00}, erx:'0,
              rchk:5'b00000, ewr:2, ewa:6'h30, ewd:8'h22, eerr:0};
    v[11] = '{n:4, cut:0, tx:{8'h0B,8'h30,8'h00,8'h00,8'h00}, erx:{8'h00,8'h00,8'h22,8'h22,8'h00},
              rchk:5'b00110, ewr:0, ewa:6'h00, ewd:8'h00, eerr:0};
`endif

    repeat (4) @(negedge clk);
    chk("reset_outputs", {17'h0, miso, miso_oe, wr_strobe, cmd_err, busy, wr_addr, wr_data}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      wr_cnt = 0;
      err_cnt = 0;
      rx = '0;
      cs_lo();
      for (int k = 0; k < v[i].n; k++) begin
        send_bits(v[i].tx[k], (k == v[i].n - 1 && v[i].cut != 0) ? v[i].cut : 8, r);
        rx[k] = r;
      end
      cs_hi();
      for (int k = 0; k < 5; k++)
        if (v[i].rchk[k]) chk($sformatf("v%0d_rx%0d", i, k), {24'h0, rx[k]}, {24'h0, v[i].erx[k]});
      chk($sformatf("v%0d_wr_cnt", i), wr_cnt, v[i].ewr);
      chk($sformatf("v%0d_err_cnt", i), err_cnt, v[i].eerr);
      if (v[i].ewr > 0) begin
        chk($sformatf("v%0d_wr_addr", i), {26'h0, last_wa}, {26'h0, v[i].ewa});
        chk($sformatf("v%0d_wr_data", i), {24'h0, last_wd}, {24'h0, v[i].ewd});
      end
      chk($sformatf("v%0d_busy_oe_mid", i), {30'h0, mid_busy, mid_oe}, 32'h3);
      chk($sformatf("v%0d_busy_oe_idle", i), {30'h0, busy, miso_oe}, 32'h0);
    end

    // Host writes, including to a read-only address.
    @(negedge clk);
    host_we = 1'b1; host_addr = 6'h08; host_wdata = 8'h7F;
    @(negedge clk);
    host_addr = 6'h01; host_wdata = 8'h77;
    @(negedge clk);
    host_we = 1'b0;
    rd_chk("host_08", 8'h08, 8'h7F);
    rd_chk("host_ro_01", 8'h01, 8'h77);

    // Reset in the middle of a transaction restores the register file.
    cs_lo();
    send_bits(8'h0B, 8, r);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outputs", {27'h0, miso, miso_oe, wr_strobe, cmd_err, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cs_hi();
    rd_chk("midrst_01", 8'h01, 8'h1D);
    rd_chk("midrst_08", 8'h08, 8'h00);
    rd_chk("midrst_2d", 8'h2D, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
